// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM with memory handshake,
// wait timeout and sticky fault trap.
module multi_cycle_control #(
   parameter int          ALU_OP_WIDTH   = 2,
   parameter logic [5:0]  OPCODE_RTYPE   = 6'b000000,
   parameter logic [5:0]  OPCODE_LW      = 6'b100011,
   parameter logic [5:0]  OPCODE_SW      = 6'b101011,
   parameter logic [5:0]  OPCODE_BNE     = 6'b000101,
   parameter logic [5:0]  OPCODE_XORI    = 6'b001110,
   parameter logic [5:0]  OPCODE_J       = 6'b000010,
   parameter int          MEMORY_TIMEOUT = 16
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [5:0]              OperationCode,
   input  logic                    MemoryReady,
   output logic                    PCWrite,
   output logic                    PCWriteCondition,
   output logic                    InstructionOrData,
   output logic                    MemoryRead,
   output logic                    MemoryWrite,
   output logic                    InstructionRegisterWrite,
   output logic                    MemoryToRegister,
   output logic                    RegisterDestination,
   output logic                    RegisterWrite,
   output logic                    ALUSourceA,
   output logic [1:0]              ALUSourceB,
   output logic [ALU_OP_WIDTH-1:0] ALUOperation,
   output logic [1:0]              PCSource,
   output logic                    SignZero,
   output logic [1:0]              Fault,
   output logic [3:0]              State
);

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_LOAD_WB   = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_JUMP      = 4'd9;
   localparam logic [3:0] S_IMM_EXEC  = 4'd10;
   localparam logic [3:0] S_IMM_WB    = 4'd11;
   localparam logic [3:0] S_TRAP      = 4'd12;

   localparam logic [1:0] F_NONE    = 2'b00;
   localparam logic [1:0] F_ILLEGAL = 2'b01;
   localparam logic [1:0] F_TIMEOUT = 2'b10;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(2'b00);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(2'b01);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_FN  = ALU_OP_WIDTH'(2'b10);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = ALU_OP_WIDTH'(2'b11);

   // Counter needs at least one bit even when the timeout is disabled.
   localparam int CW = (MEMORY_TIMEOUT < 1) ? 1 : $clog2(MEMORY_TIMEOUT + 1);
   localparam logic [CW:0] TO_V  = (CW + 1)'(MEMORY_TIMEOUT);
   localparam logic        TO_EN = (MEMORY_TIMEOUT > 0);

   logic [3:0]    state_q, state_d;
   logic [1:0]    fault_q, fault_d;
   logic [5:0]    op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0]   cnt_inc;
   logic          wait_st;
   logic          timeout;

   // Next-state, opcode capture, wait counter and fault logic.
   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      op_d    = op_q;
      cnt_d   = '0;
      cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
      wait_st = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                (state_q == S_MEM_WRITE);
      timeout = wait_st && !MemoryReady && TO_EN && (cnt_inc == TO_V);
      case (state_q)
         S_FETCH:     if (MemoryReady) state_d = S_DECODE;
         S_DECODE: begin
            op_d = OperationCode;
            case (OperationCode)
               OPCODE_RTYPE: state_d = S_R_EXEC;
               OPCODE_LW:    state_d = S_MEM_ADDR;
               OPCODE_SW:    state_d = S_MEM_ADDR;
               OPCODE_BNE:   state_d = S_BRANCH;
               OPCODE_J:     state_d = S_JUMP;
               OPCODE_XORI:  state_d = S_IMM_EXEC;
               default: begin
                  state_d = S_TRAP;
                  fault_d = F_ILLEGAL;
               end
            endcase
         end
         S_MEM_ADDR:  state_d = (op_q == OPCODE_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (MemoryReady) state_d = S_LOAD_WB;
         S_LOAD_WB:   state_d = S_FETCH;
         S_MEM_WRITE: if (MemoryReady) state_d = S_FETCH;
         S_R_EXEC:    state_d = S_R_WB;
         S_R_WB:      state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_IMM_EXEC:  state_d = S_IMM_WB;
         S_IMM_WB:    state_d = S_FETCH;
         S_TRAP:      state_d = S_TRAP;
         default:     state_d = S_FETCH;
      endcase
      if (wait_st && !MemoryReady) cnt_d = cnt_inc[CW-1:0];
      if (timeout) begin
         state_d = S_TRAP;
         fault_d = F_TIMEOUT;
         cnt_d   = '0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= S_FETCH;
         fault_q <= F_NONE;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   // Moore outputs per state, all forced low while in reset.
   always_comb begin
      PCWrite                  = 1'b0;
      PCWriteCondition         = 1'b0;
      InstructionOrData        = 1'b0;
      MemoryRead               = 1'b0;
      MemoryWrite              = 1'b0;
      InstructionRegisterWrite = 1'b0;
      MemoryToRegister         = 1'b0;
      RegisterDestination      = 1'b0;
      RegisterWrite            = 1'b0;
      ALUSourceA               = 1'b0;
      ALUSourceB               = 2'b00;
      ALUOperation             = ALU_ADD;
      PCSource                 = 2'b00;
      SignZero                 = 1'b0;
      Fault                    = Reset ? fault_q : F_NONE;
      State                    = state_q;
      if (Reset) begin
         case (state_q)
            S_FETCH: begin
               MemoryRead               = 1'b1;
               ALUSourceB               = 2'b01;
               PCWrite                  = MemoryReady;
               InstructionRegisterWrite = MemoryReady;
            end
            S_DECODE:    ALUSourceB = 2'b11;
            S_MEM_ADDR: begin
               ALUSourceA = 1'b1;
               ALUSourceB = 2'b10;
            end
            S_MEM_READ: begin
               MemoryRead        = 1'b1;
               InstructionOrData = 1'b1;
            end
            S_LOAD_WB: begin
               RegisterWrite    = 1'b1;
               MemoryToRegister = 1'b1;
            end
            S_MEM_WRITE: begin
               MemoryWrite       = 1'b1;
               InstructionOrData = 1'b1;
            end
            S_R_EXEC: begin
               ALUSourceA   = 1'b1;
               ALUOperation = ALU_FN;
            end
            S_R_WB: begin
               RegisterWrite       = 1'b1;
               RegisterDestination = 1'b1;
            end
            S_BRANCH: begin
               ALUSourceA       = 1'b1;
               ALUOperation     = ALU_SUB;
               PCWriteCondition = 1'b1;
               PCSource         = 2'b01;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
            S_IMM_EXEC: begin
               ALUSourceA   = 1'b1;
               ALUSourceB   = 2'b10;
               ALUOperation = ALU_XOR;
               SignZero     = 1'b1;
            end
            S_IMM_WB: begin
               RegisterWrite = 1'b1;
               SignZero      = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed-vector bench for multi_cycle_control
// (built with MEMORY_TIMEOUT=4).
module tb_multi_cycle_control;

   logic       Clock;
   logic       Reset;
   logic [5:0] OperationCode;
   logic       MemoryReady;
   logic       PCWrite, PCWriteCondition, InstructionOrData;
   logic       MemoryRead, MemoryWrite, InstructionRegisterWrite;
   logic       MemoryToRegister, RegisterDestination, RegisterWrite;
   logic       ALUSourceA, SignZero;
   logic [1:0] ALUSourceB, ALUOperation, PCSource, Fault;
   logic [3:0] State;

   multi_cycle_control #(.MEMORY_TIMEOUT(4)) dut (
      .Clock(Clock), .Reset(Reset),
      .OperationCode(OperationCode), .MemoryReady(MemoryReady),
      .PCWrite(PCWrite), .PCWriteCondition(PCWriteCondition),
      .InstructionOrData(InstructionOrData),
      .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
      .InstructionRegisterWrite(InstructionRegisterWrite),
      .MemoryToRegister(MemoryToRegister),
      .RegisterDestination(RegisterDestination),
      .RegisterWrite(RegisterWrite), .ALUSourceA(ALUSourceA),
      .ALUSourceB(ALUSourceB), .ALUOperation(ALUOperation),
      .PCSource(PCSource), .SignZero(SignZero),
      .Fault(Fault), .State(State)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // {PCW,PCWC,IorD,MR,MW,IRW,M2R,RD,RW,ASA}_ASB_AOP_PCS_SZ_FAULT
   localparam logic [18:0] O_ZERO  = 19'b0000000000_00_00_00_0_00;
   localparam logic [18:0] O_FETR  = 19'b1001010000_01_00_00_0_00;
   localparam logic [18:0] O_FETW  = 19'b0001000000_01_00_00_0_00;
   localparam logic [18:0] O_DEC   = 19'b0000000000_11_00_00_0_00;
   localparam logic [18:0] O_MADDR = 19'b0000000001_10_00_00_0_00;
   localparam logic [18:0] O_MRD   = 19'b0011000000_00_00_00_0_00;
   localparam logic [18:0] O_LWB   = 19'b0000001010_00_00_00_0_00;
   localparam logic [18:0] O_MWR   = 19'b0010100000_00_00_00_0_00;
   localparam logic [18:0] O_REX   = 19'b0000000001_00_10_00_0_00;
   localparam logic [18:0] O_RWB   = 19'b0000000110_00_00_00_0_00;
   localparam logic [18:0] O_BR    = 19'b0100000001_00_01_01_0_00;
   localparam logic [18:0] O_JMP   = 19'b1000000000_00_00_10_0_00;
   localparam logic [18:0] O_IEX   = 19'b0000000001_10_11_00_1_00;
   localparam logic [18:0] O_IWB   = 19'b0000000010_00_00_00_1_00;
   localparam logic [18:0] O_TILL  = 19'b0000000000_00_00_00_0_01;
   localparam logic [18:0] O_TTMO  = 19'b0000000000_00_00_00_0_10;

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011;
   localparam logic [5:0] SW = 6'b101011, BNE = 6'b000101;
   localparam logic [5:0] XI = 6'b001110, JJ = 6'b000010;
   localparam logic [5:0] BAD = 6'b111111;

   typedef struct {
      logic        rst_n;
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [18:0] o;
   } vec_t;

   vec_t vecs[$];
   int   applied;
   int   miscompares;
   logic [18:0] got;

   assign got = {PCWrite, PCWriteCondition, InstructionOrData,
                 MemoryRead, MemoryWrite, InstructionRegisterWrite,
                 MemoryToRegister, RegisterDestination, RegisterWrite,
                 ALUSourceA, ALUSourceB, ALUOperation, PCSource,
                 SignZero, Fault};

   task automatic add(input logic r, input logic [5:0] op,
                      input logic rdy, input logic [3:0] st,
                      input logic [18:0] o);
      vec_t v;
      v.rst_n = r; v.op = op; v.rdy = rdy; v.st = st; v.o = o;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs after the falling edge, then compare.
   task automatic apply(input string name, input logic r,
                        input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic [18:0] o);
      @(negedge Clock);
      Reset = r; OperationCode = op; MemoryReady = rdy;
      #1;
      applied++;
      if (State !== st || got !== o) begin
         miscompares++;
         $display("FAIL %s: state=%0d outs=%b, want state=%0d outs=%b",
                  name, State, got, st, o);
      end
   endtask

   initial begin
      Reset = 1'b0; OperationCode = RT; MemoryReady = 1'b1;
      applied = 0; miscompares = 0;
      @(posedge Clock);

      // reset two cycles, then release into FETCH
      add(0, RT, 1, 0, O_ZERO);
      add(0, RT, 1, 0, O_ZERO);
      add(1, RT, 1, 0, O_FETR);
      // R-type
      add(1, RT, 1, 1, O_DEC);
      add(1, RT, 1, 6, O_REX);
      add(1, RT, 1, 7, O_RWB);
      // LW with 3 wait cycles, opcode garbage outside DECODE
      add(1, BAD, 1, 0, O_FETR);
      add(1, LW, 1, 1, O_DEC);
      add(1, SW, 1, 2, O_MADDR);
      add(1, BAD, 0, 3, O_MRD);
      add(1, BAD, 0, 3, O_MRD);
      add(1, BAD, 0, 3, O_MRD);
      add(1, BAD, 1, 3, O_MRD);
      add(1, BAD, 1, 4, O_LWB);
      // SW, BNE, J back to back
      add(1, BAD, 1, 0, O_FETR);
      add(1, SW, 1, 1, O_DEC);
      add(1, LW, 1, 2, O_MADDR);
      add(1, BAD, 1, 5, O_MWR);
      add(1, BAD, 1, 0, O_FETR);
      add(1, BNE, 1, 1, O_DEC);
      add(1, BAD, 1, 8, O_BR);
      add(1, BAD, 1, 0, O_FETR);
      add(1, JJ, 1, 1, O_DEC);
      add(1, BAD, 1, 9, O_JMP);
      // FETCH wait then XORI
      add(1, BAD, 0, 0, O_FETW);
      add(1, BAD, 1, 0, O_FETR);
      add(1, XI, 1, 1, O_DEC);
      add(1, BAD, 1, 10, O_IEX);
      add(1, BAD, 1, 11, O_IWB);
      // reset mid-instruction
      add(1, BAD, 1, 0, O_FETR);
      add(1, RT, 1, 1, O_DEC);
      add(0, RT, 1, 6, O_ZERO);
      add(1, RT, 1, 0, O_FETR);
      // illegal opcode into TRAP
      add(1, BAD, 1, 1, O_DEC);
      for (int i = 0; i < 20; i++)
         add(1, RT, 1'(i % 2), 12, O_TILL);
      add(0, RT, 1, 12, O_ZERO);
      add(0, RT, 1, 0, O_ZERO);
      add(1, RT, 1, 0, O_FETR);

      foreach (vecs[i])
         apply($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].op,
               vecs[i].rdy, vecs[i].st, vecs[i].o);

      // FETCH timeout: 4 not-ready cycles then TRAP, fault 10
      apply("rst_a", 0, RT, 0, 1, O_ZERO);
      for (int i = 0; i < 4; i++)
         apply($sformatf("fto_wait%0d", i), 1, RT, 0, 0, O_FETW);
      for (int i = 0; i < 3; i++)
         apply($sformatf("fto_trap%0d", i), 1, RT, 1'(i % 2), 12, O_TTMO);
      // rerun: ready on the 4th cycle counts as completion
      apply("rst_b", 0, RT, 0, 12, O_ZERO);
      for (int i = 0; i < 3; i++)
         apply($sformatf("frdy_wait%0d", i), 1, RT, 0, 0, O_FETW);
      apply("frdy_go", 1, RT, 1, 0, O_FETR);
      apply("frdy_dec", 1, SW, 1, 1, O_DEC);
      apply("mw_addr", 1, BAD, 1, 2, O_MADDR);
      // MEM_WRITE timeout
      for (int i = 0; i < 4; i++)
         apply($sformatf("mwto_wait%0d", i), 1, BAD, 0, 5, O_MWR);
      apply("mwto_trap", 1, BAD, 1, 12, O_TTMO);
      apply("rst_c", 0, RT, 1, 12, O_ZERO);
      apply("post_rst", 1, RT, 1, 0, O_FETR);

      $display("== %0d vectors applied, %0d miscompares ==",
               applied, miscompares);
      $finish;
   end

endmodule
